fifo_umbral: RTL and testbench

Per-destination buffer that sits on the push side of the arbiter. The arbiter writes words into it with `push` and throttles itself on `afull`. The downstream consumer drains it with `pop` and watches `empty`/`aempty`. Four instances, one per destination, supply the arbiter's `afull0..3` and receive its `push0..3`. The same block is reused on the ingress side, where it supplies `empty0..3` and receives `pop0..3`.

---
 rtl/fifo_umbral.sv | 97 +++++++++
 tb/tb_fifo_umbral.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_umbral.sv
// fifo_umbral: per-destination word buffer with programmable almost-full /
// almost-empty thresholds. Depth is 2**ADDR_WIDTH.
// The FIFO_ERROR_EN macro builds a sticky overflow/underflow flag.
// When the macro is undefined, `error` is tied low.
// Flags decode only the registered occupancy count. The threshold inputs are
// the only combinational path to an output (afull/aempty).
module fifo_umbral #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic                  empty,
  output logic                  full,
  output logic                  afull,
  output logic                  aempty,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // A push into a full FIFO is legal only when a pop frees a slot on the same edge.
  // A pop from an empty FIFO is never legal.
  // Because of that, an empty FIFO with push and pop both high performs only the push.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Status flags decode the registered count. The thresholds are used live.
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign afull  = (count >= umbral_alto);
  assign aempty = (count <= umbral_bajo);

  // Storage array: written on an accepted push, contents not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= mem[rd_ptr];
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count <= count - CNT_ONE;
      end
    end
  end

`ifdef FIFO_ERROR_EN
  logic error_q;

  // Sticky flag: set by a rejected push (full, no pop) or a rejected pop (empty).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if ((push && full && !pop) || (pop && empty)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: directed stimulus for fifo_umbral.
// A queue-based reference model is compared against the DUT on every falling
// clock edge. Literal expectations pin the model at the key points.
module tb_fifo_umbral;

  localparam int DW = 10;
  localparam int AW = 3;
`ifdef FIFO_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [AW:0]   umbral_alto;
  logic [AW:0]   umbral_bajo;
  logic          empty;
  logic          full;
  logic          afull;
  logic          aempty;
  logic          error;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Reference model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_err = 1'b0;

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .data_in    (data_in),
    .pop        (pop),
    .data_out   (data_out),
    .umbral_alto(umbral_alto),
    .umbral_bajo(umbral_bajo),
    .empty      (empty),
    .full       (full),
    .afull      (afull),
    .aempty     (aempty),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO queue with the spec's accept/reject rules.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_dout = '0;
      m_err  = 1'b0;
    end else begin
      int sz;
      bit acc_push;
      bit acc_pop;
      sz = q.size();
      acc_push = push && (sz < 8 || pop);
      acc_pop  = pop && sz > 0;
      if ((push && sz == 8 && !pop) || (pop && sz == 0)) m_err = ERR_EN;
      if (acc_pop) m_dout = q.pop_front();
      if (acc_push) q.push_back(data_in);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_empty",  32'(empty),    32'(q.size() == 0));
      chk("m_full",   32'(full),     32'(q.size() == 8));
      chk("m_afull",  32'(afull),    32'(q.size() >= int'(umbral_alto)));
      chk("m_aempty", 32'(aempty),   32'(q.size() <= int'(umbral_bajo)));
      chk("m_dout",   32'(data_out), 32'(m_dout));
      chk("m_error",  32'(error),    32'(m_err));
    end
  end

  task automatic cyc(input bit p, input bit r, input logic [DW-1:0] d);
    push = p;
    pop = r;
    data_in = d;
    @(posedge clk);
    #2;
    push = 1'b0;
    pop = 1'b0;
  endtask

  initial begin
    push = 0; pop = 0; data_in = '0;
    umbral_alto = 4'd6; umbral_bajo = 4'd1;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_aempty", 32'(aempty), 1);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_error", 32'(error), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    cmp_en = 1'b1;

    // Fill with 1..8.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, DW'(i));
      chk("fill_empty", 32'(empty), 0);
      if (i == 1) chk("fill1_aempty", 32'(aempty), 1);
      if (i == 2) chk("fill2_aempty", 32'(aempty), 0);
      if (i == 5) chk("fill5_afull", 32'(afull), 0);
      if (i == 6) chk("fill6_afull", 32'(afull), 1);
      if (i == 7) chk("fill7_full", 32'(full), 0);
      if (i == 8) chk("fill8_full", 32'(full), 1);
    end

    // Overflow attempt, then drain.
    cyc(1, 0, 10'h3FF);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_error", 32'(error), 32'(ERR_EN));
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, '0);
      chk("drain_dout", 32'(data_out), 32'(i));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_error", 32'(error), 32'(ERR_EN));

    // Push and pop together while empty.
    cyc(1, 1, 10'h155);
    chk("pp_empty_dout", 32'(data_out), 8);
    chk("pp_empty_empty", 32'(empty), 0);
    cyc(0, 1, '0);
    chk("pp_empty_pop", 32'(data_out), 32'h155);
    chk("pp_empty_after", 32'(empty), 1);

    // Push and pop together while full, with pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1, 0, DW'(32'h10 + i));
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 10'h2AA);
      chk("pp_full_full", 32'(full), 1);
      chk("pp_full_dout", 32'(data_out), (i < 8) ? 32'(32'h10 + i) : 32'h2AA);
    end

    // Asynchronous reset with five words stored.
    repeat (3) cyc(0, 1, '0);
    reset = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_dout", 32'(data_out), 0);
    chk("arst_full", 32'(full), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    cyc(1, 0, 10'h0AB);
    cyc(0, 1, '0);
    chk("post_rst_dout", 32'(data_out), 32'h0AB);
    chk("post_rst_empty", 32'(empty), 1);

    // Live threshold sweep on an empty FIFO.
    umbral_alto = 4'd0;
    #1 chk("thr0_afull", 32'(afull), 1);
    umbral_alto = 4'd9;
    #1 chk("thr9_afull", 32'(afull), 0);
    @(negedge clk);
    umbral_alto = 4'd6;

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
